// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: tracks in-flight destinations, forwards youngest producer results, stalls on load-use
module forwarding_scoreboard #(
  parameter int REG_W      = 5,
  parameter int NRD        = 2,
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 32,
  parameter int LOAD_STAGE = 1
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    issue_valid_i,
  input  logic                    issue_wen_i,
  input  logic [REG_W-1:0]        issue_wsel_i,
  input  logic                    issue_is_load_i,
  input  logic [NRD*REG_W-1:0]    rsel_i,
  input  logic [NRD*DATA_W-1:0]   rdata_rf_i,
  input  logic [DEPTH*DATA_W-1:0] stage_data_i,
  input  logic                    stall_ext_i,
  input  logic                    flush_i,
  output logic [NRD*DATA_W-1:0]   fwd_data_o,
  output logic [NRD-1:0]          fwd_hit_o,
  output logic                    hazard_stall_o,
  output logic [15:0]             stall_cnt_o
);
  logic [DEPTH-1:0]             v_q, v_d, ld_q, ld_d;
  logic [DEPTH-1:0][REG_W-1:0]  wsel_q, wsel_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic [NRD-1:0]               blk;
  always_comb begin
    blk        = '0;
    fwd_hit_o  = '0;
    fwd_data_o = rdata_rf_i;
    for (int p = 0; p < NRD; p++)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (v_q[k] && wsel_q[k] == rsel_i[p*REG_W +: REG_W] && rsel_i[p*REG_W +: REG_W] != '0) begin
          blk[p]                      = ld_q[k] && k < LOAD_STAGE;
          fwd_hit_o[p]                = !blk[p];
          fwd_data_o[p*DATA_W +: DATA_W] = blk[p] ? rdata_rf_i[p*DATA_W +: DATA_W] : stage_data_i[k*DATA_W +: DATA_W];
        end
  end
  assign hazard_stall_o = |blk;
  assign stall_cnt_o    = cnt_q;
  always_comb begin
    v_d    = {v_q[DEPTH-2:0], issue_valid_i & issue_wen_i & (issue_wsel_i != '0) & ~flush_i & ~hazard_stall_o};
    wsel_d = {wsel_q[DEPTH-2:0], issue_wsel_i};
    ld_d   = {ld_q[DEPTH-2:0], issue_is_load_i};
    cnt_d  = cnt_q + {15'd0, hazard_stall_o & (cnt_q != 16'hFFFF)};
  end
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      v_q    <= '0;
      wsel_q <= '0;
      ld_q   <= '0;
      cnt_q  <= '0;
    end else if (!stall_ext_i) begin
      v_q    <= v_d;
      wsel_q <= wsel_d;
      ld_q   <= ld_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
